mult_cdb_buffer: RTL and testbench

Completion buffer and issue throttle for the two pipelined multiplier lanes (C and D). Captures each lane's done pulse with its product and tags into a small in-order FIFO, presents one completion per cycle to the CDB slot through a req/gnt handshake, and holds back multiplier issue whenever the buffer cannot absorb every in-flight multiply. The block sits between the multiplier pipes and the CDB arbiter, and receives the ROB's flush.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/mult_cpl_fifo.sv | 83 ++++++++
 rtl/mult_cdb_buffer.sv | 101 ++++++++++
 tb/tb_mult_cdb_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier completion buffer.
package mult_pkg;

    localparam int DEPTH_DEFAULT    = 4;
    localparam int MULT_LAT_DEFAULT = 4;
    localparam int MULT_IDLE_IDX    = 31;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] NPC;
        logic [5:0]  pr_idx;
        logic [4:0]  mt_idx;
        logic [4:0]  rob_idx;
    } mult_cpl_t;

    // Value shown on the CDB fields whenever nothing is buffered.
    localparam mult_cpl_t MULT_IDLE_CPL = '{
        result:  64'd0,
        NPC:     64'd0,
        pr_idx:  6'(MULT_IDLE_IDX),
        mt_idx:  5'(MULT_IDLE_IDX),
        rob_idx: 5'(MULT_IDLE_IDX)
    };

endpackage

// File: rtl/mult_cpl_fifo.sv
// Two-write / one-read in-order FIFO of multiplier completions.
// Lane C is always written before lane D so it stays the older entry.
module mult_cpl_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_c_i,
    input  mult_cpl_t                    data_c_i,
    input  logic                         push_d_i,
    input  mult_cpl_t                    data_d_i,
    input  logic                         pop_i,
    output mult_cpl_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    mult_cpl_t     mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          pop, want_c, want_d, keep_c, keep_d;
    logic [CW:0]   free_slots;
    logic [PW-1:0] addr_d;

    // Work out which pushes fit (a same-cycle pop frees its slot) and the next pointers/count.
    always_comb begin
        want_c     = push_c_i && !flush_i;
        want_d     = push_d_i && !flush_i;
        pop        = pop_i && (count_q != '0);
        free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
        keep_c     = want_c && (free_slots != '0);
        keep_d     = want_d && (free_slots > {{CW{1'b0}}, keep_c});
        addr_d     = wr_ptr_q + PW'(keep_c);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(keep_c) + PW'(keep_d);
        count_d    = count_q + CW'(keep_c) + CW'(keep_d) - CW'(pop);
        overflow_d = overflow_q || (want_c && !keep_c) || (want_d && !keep_d);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Occupancy state; reset empties the buffer without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage has no reset; count alone decides which slots are valid.
    always_ff @(posedge clock) begin
        if (keep_c) mem_q[wr_ptr_q] <= data_c_i;
        if (keep_d) mem_q[addr_d]   <= data_d_i;
    end

    // Head is forced to the idle pattern whenever the buffer is empty.
    always_comb begin
        head_o = MULT_IDLE_CPL;
        if (count_q != '0) head_o = mem_q[rd_ptr_q];
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/mult_cdb_buffer.sv
// Completion buffer and issue throttle between multiplier lanes C/D and the CDB.
// Tracks in-flight multiplies so issue is held back before the buffer could overflow,
// and discards stale completions for a fixed window after a flush.
module mult_cdb_buffer
    import mult_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issueC,
    input  logic        issueD,
    input  logic        doneC,
    input  logic        doneD,
    input  logic [63:0] resultC,
    input  logic [63:0] resultD,
    input  logic [63:0] NPCC,
    input  logic [63:0] NPCD,
    input  logic [5:0]  pr_idxC,
    input  logic [5:0]  pr_idxD,
    input  logic [4:0]  mt_idxC,
    input  logic [4:0]  mt_idxD,
    input  logic [4:0]  rob_idxC,
    input  logic [4:0]  rob_idxD,
    input  logic        flush,
    input  logic        cdb_gnt,
    output logic        cdb_req,
    output logic [63:0] cdb_result,
    output logic [63:0] cdb_NPC,
    output logic [5:0]  cdb_pr_idx,
    output logic [4:0]  cdb_mt_idx,
    output logic [4:0]  cdb_rob_idx,
    output logic        mult_stall,
    output logic        overflow_err
);

    localparam int IW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(MULT_LAT + 1);

    logic [IW-1:0] inflight_q, inflight_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [IW-1:0] count;
    logic          drop_window, acc_c, acc_d, pop;
    int            inflight_sum;
    mult_cpl_t     cpl_c, cpl_d, head;

    assign cpl_c = '{result: resultC, NPC: NPCC, pr_idx: pr_idxC, mt_idx: mt_idxC, rob_idx: rob_idxC};
    assign cpl_d = '{result: resultD, NPC: NPCD, pr_idx: pr_idxD, mt_idx: mt_idxD, rob_idx: rob_idxD};

    // Filter done pulses through the flush window and update the in-flight and drop counters.
    always_comb begin
        drop_window  = flush || (drop_q != '0);
        acc_c        = doneC && !drop_window;
        acc_d        = doneD && !drop_window;
        inflight_sum = int'(inflight_q) + int'(issueC) + int'(issueD) - int'(acc_c) - int'(acc_d);
        if (flush)                   inflight_d = '0;
        else if (inflight_sum < 0)   inflight_d = '0;
        else if (inflight_sum > DEPTH) inflight_d = IW'(DEPTH);
        else                         inflight_d = IW'(inflight_sum);
        if (flush)                   drop_d = DW'(MULT_LAT);
        else if (drop_q != '0)       drop_d = drop_q - DW'(1);
        else                         drop_d = drop_q;
    end

    // Counter registers; both return to zero on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign pop = cdb_req && cdb_gnt && !flush;

    mult_cpl_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush_i    (flush),
        .push_c_i   (acc_c),
        .data_c_i   (cpl_c),
        .push_d_i   (acc_d),
        .data_d_i   (cpl_d),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .overflow_o (overflow_err)
    );

    assign cdb_req     = (count != '0);
    assign cdb_result  = head.result;
    assign cdb_NPC     = head.NPC;
    assign cdb_pr_idx  = head.pr_idx;
    assign cdb_mt_idx  = head.mt_idx;
    assign cdb_rob_idx = head.rob_idx;
    assign mult_stall  = (int'(count) + int'(inflight_q) + 2) > DEPTH;

endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Self-checking bench for mult_cdb_buffer: the bench plays both multiplier lanes
// (fixed latency pipes) and compares the DUT against a queue-based completion model.
`timescale 1ns/1ps
module tb_mult_cdb_buffer;
    import mult_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MULT_LAT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        issueC, issueD, doneC, doneD, flush, cdb_gnt;
    logic [63:0] resultC, resultD, NPCC, NPCD;
    logic [5:0]  pr_idxC, pr_idxD;
    logic [4:0]  mt_idxC, mt_idxD, rob_idxC, rob_idxD;
    logic        cdb_req, mult_stall, overflow_err;
    logic [63:0] cdb_result, cdb_NPC;
    logic [5:0]  cdb_pr_idx;
    logic [4:0]  cdb_mt_idx, cdb_rob_idx;

    mult_cdb_buffer #(.DEPTH(DEPTH), .MULT_LAT(MULT_LAT)) dut (
        .clock(clock), .reset(reset),
        .issueC(issueC), .issueD(issueD), .doneC(doneC), .doneD(doneD),
        .resultC(resultC), .resultD(resultD), .NPCC(NPCC), .NPCD(NPCD),
        .pr_idxC(pr_idxC), .pr_idxD(pr_idxD), .mt_idxC(mt_idxC), .mt_idxD(mt_idxD),
        .rob_idxC(rob_idxC), .rob_idxD(rob_idxD), .flush(flush), .cdb_gnt(cdb_gnt),
        .cdb_req(cdb_req), .cdb_result(cdb_result), .cdb_NPC(cdb_NPC),
        .cdb_pr_idx(cdb_pr_idx), .cdb_mt_idx(cdb_mt_idx), .cdb_rob_idx(cdb_rob_idx),
        .mult_stall(mult_stall), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    typedef struct { int due; mult_cpl_t pay; } job_t;

    job_t      pendC[$], pendD[$];
    mult_cpl_t mq[$];
    int        mInflight, mDrop;
    bit        mOvf;
    int        cyc;
    int        checks, passed;
    mult_cpl_t payC, payD;

    function automatic mult_cpl_t rand_cpl();
        mult_cpl_t p;
        p.result  = {$urandom, $urandom};
        p.NPC     = {$urandom, $urandom};
        p.pr_idx  = 6'($urandom_range(0, 63));
        p.mt_idx  = 5'($urandom_range(0, 31));
        p.rob_idx = 5'($urandom_range(0, 31));
        return p;
    endfunction

    function automatic mult_cpl_t dut_head();
        mult_cpl_t p;
        p.result = cdb_result; p.NPC = cdb_NPC; p.pr_idx = cdb_pr_idx;
        p.mt_idx = cdb_mt_idx; p.rob_idx = cdb_rob_idx;
        return p;
    endfunction

    function automatic mult_cpl_t exp_head();
        if (mq.size() != 0) return mq[0];
        return MULT_IDLE_CPL;
    endfunction

    function automatic bit exp_stall();
        return (mq.size() + mInflight) >= 3;
    endfunction

    // Drive one cycle (called at a negedge), update the reference model, return at the next negedge.
    task automatic applyStimulus(input bit iC, input bit iD, input bit fl, input bit gnt,
                                 input bit fC = 1'b0, input bit fD = 1'b0);
        bit dC, dD, win;
        int acc;
        mult_cpl_t pC, pD;
        if (fl || ((mq.size() + mInflight + 2) > DEPTH)) begin iC = 1'b0; iD = 1'b0; end
        dC = 1'b0; dD = 1'b0; pC = rand_cpl(); pD = rand_cpl();
        if (pendC.size() != 0 && pendC[0].due == cyc) begin
            dC = 1'b1; pC = pendC[0].pay; void'(pendC.pop_front());
        end else if (fC) dC = 1'b1;
        if (pendD.size() != 0 && pendD[0].due == cyc) begin
            dD = 1'b1; pD = pendD[0].pay; void'(pendD.pop_front());
        end else if (fD) dD = 1'b1;
        if (iC) begin pendC.push_back('{due: cyc + MULT_LAT, pay: payC}); payC = rand_cpl(); end
        if (iD) begin pendD.push_back('{due: cyc + MULT_LAT, pay: payD}); payD = rand_cpl(); end
        issueC = iC; issueD = iD; doneC = dC; doneD = dD; flush = fl; cdb_gnt = gnt;
        resultC = pC.result; NPCC = pC.NPC; pr_idxC = pC.pr_idx; mt_idxC = pC.mt_idx; rob_idxC = pC.rob_idx;
        resultD = pD.result; NPCD = pD.NPC; pr_idxD = pD.pr_idx; mt_idxD = pD.mt_idx; rob_idxD = pD.rob_idx;
        #1;
        assert (!((issueC || issueD) && mult_stall))
            else $error("[TB] FAIL protocol: issue while mult_stall=1 at cycle %0d", cyc);
        win = fl || (mDrop != 0);
        if (fl) begin
            mq.delete(); mInflight = 0; mDrop = MULT_LAT;
        end else begin
            if (gnt && mq.size() != 0) void'(mq.pop_front());
            acc = 0;
            if (!win) begin
                if (dC) begin acc++; if (mq.size() < DEPTH) mq.push_back(pC); else mOvf = 1'b1; end
                if (dD) begin acc++; if (mq.size() < DEPTH) mq.push_back(pD); else mOvf = 1'b1; end
            end
            mInflight = mInflight + int'(iC) + int'(iD) - acc;
            if (mInflight < 0) mInflight = 0;
            if (mInflight > DEPTH) mInflight = DEPTH;
            if (mDrop > 0) mDrop--;
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic test_reset();
        issueC = 0; issueD = 0; doneC = 0; doneD = 0; flush = 0; cdb_gnt = 0;
        resultC = '0; resultD = '0; NPCC = '0; NPCD = '0; pr_idxC = '0; pr_idxD = '0;
        mt_idxC = '0; mt_idxD = '0; rob_idxC = '0; rob_idxD = '0;
        reset = 1'b0;
        #17;
        checks++; if (cdb_req !== 1'b0) $display("[TB] FAIL reset_req got %b want 0", cdb_req); else passed++;
        checks++; if (mult_stall !== 1'b0) $display("[TB] FAIL reset_stall got %b want 0", mult_stall); else passed++;
        checks++; if (overflow_err !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", overflow_err); else passed++;
        checks++; if (dut_head() !== MULT_IDLE_CPL) $display("[TB] FAIL reset_idle got %h want %h", dut_head(), MULT_IDLE_CPL); else passed++;
        @(negedge clock);
        reset = 1'b1;
        mq.delete(); mInflight = 0; mDrop = 0; mOvf = 1'b0; cyc = 0;
        payC = rand_cpl(); payD = rand_cpl();
        applyStimulus(0, 0, 0, 0);
        checks++; if (cdb_req !== 1'b0 || cdb_pr_idx !== 6'd31) $display("[TB] FAIL post_reset got req=%b pr=%0d want 0/31", cdb_req, cdb_pr_idx); else passed++;
    endtask

    task automatic test_single();
        payC = rand_cpl(); payC.result = 64'h2A; payC.pr_idx = 6'd7; payC.rob_idx = 5'd3;
        applyStimulus(1, 0, 0, 1);
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (cdb_req !== (c == 5)) $display("[TB] FAIL single_req cycle %0d got %b want %b", c, cdb_req, (c == 5)); else passed++;
            if (c == 5) begin
                checks++;
                if (cdb_result !== 64'h2A || cdb_pr_idx !== 6'd7 || cdb_rob_idx !== 5'd3)
                    $display("[TB] FAIL single_fields got %h/%0d/%0d want 2a/7/3", cdb_result, cdb_pr_idx, cdb_rob_idx);
                else passed++;
            end
            applyStimulus(0, 0, 0, 1);
        end
    endtask

    task automatic test_dual_same_cycle();
        mult_cpl_t c1, d1;
        payC = rand_cpl(); payD = rand_cpl(); c1 = payC; d1 = payD;
        applyStimulus(1, 1, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        checks++; if (cdb_req !== 1'b1 || dut_head() !== c1) $display("[TB] FAIL dual_first got req=%b %h want 1 %h", cdb_req, dut_head(), c1); else passed++;
        checks++; if (mult_stall !== 1'b0) $display("[TB] FAIL dual_stall got %b want 0", mult_stall); else passed++;
        applyStimulus(0, 0, 0, 1);
        checks++; if (cdb_req !== 1'b1 || dut_head() !== d1) $display("[TB] FAIL dual_second got req=%b %h want 1 %h", cdb_req, dut_head(), d1); else passed++;
        applyStimulus(0, 0, 0, 1);
        checks++; if (cdb_req !== 1'b0 || cdb_pr_idx !== 6'd31) $display("[TB] FAIL dual_empty got req=%b pr=%0d want 0/31", cdb_req, cdb_pr_idx); else passed++;
    endtask

    task automatic test_stall_fill();
        int popped;
        for (int n = 0; n < 14; n++) begin
            applyStimulus(1, 1, 0, 0);
            checks++; if (mult_stall !== exp_stall()) $display("[TB] FAIL fill_stall cycle %0d got %b want %b", n, mult_stall, exp_stall()); else passed++;
            checks++; if (overflow_err !== 1'b0) $display("[TB] FAIL fill_ovf cycle %0d got %b want 0", n, overflow_err); else passed++;
        end
        popped = 0;
        for (int n = 0; n < 6; n++) begin
            checks++; if (dut_head() !== exp_head()) $display("[TB] FAIL fill_order step %0d got %h want %h", n, dut_head(), exp_head()); else passed++;
            if (cdb_req === 1'b1) popped++;
            applyStimulus(0, 0, 0, 1);
        end
        checks++; if (popped !== 4) $display("[TB] FAIL fill_drained got %0d want 4", popped); else passed++;
    endtask

    task automatic test_wrap();
        mult_cpl_t c1, d1, c2, d2;
        payC = rand_cpl(); payD = rand_cpl(); c1 = payC; d1 = payD;
        applyStimulus(1, 1, 0, 0);
        payC = rand_cpl(); payD = rand_cpl(); c2 = payC; d2 = payD;
        applyStimulus(1, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        checks++; if (cdb_req !== 1'b1 || dut_head() !== c1) $display("[TB] FAIL wrap_head0 got %h want %h", dut_head(), c1); else passed++;
        applyStimulus(0, 0, 0, 1);
        checks++; if (mult_stall !== 1'b1 || dut_head() !== d1) $display("[TB] FAIL wrap_pop_push got stall=%b %h want 1 %h", mult_stall, dut_head(), d1); else passed++;
        applyStimulus(0, 0, 0, 1);
        checks++; if (dut_head() !== c2) $display("[TB] FAIL wrap_head2 got %h want %h", dut_head(), c2); else passed++;
        applyStimulus(0, 0, 0, 1);
        checks++; if (dut_head() !== d2) $display("[TB] FAIL wrap_head3 got %h want %h", dut_head(), d2); else passed++;
        applyStimulus(0, 0, 0, 1);
        checks++; if (cdb_req !== 1'b0) $display("[TB] FAIL wrap_empty got %b want 0", cdb_req); else passed++;
    endtask

    task automatic test_flush();
        mult_cpl_t cf;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        checks++; if (cdb_req !== 1'b1) $display("[TB] FAIL flush_pre got %b want 1", cdb_req); else passed++;
        applyStimulus(0, 0, 1, 0);
        checks++; if (cdb_req !== 1'b0 || mult_stall !== 1'b0) $display("[TB] FAIL flush_f1 got req=%b stall=%b want 0/0", cdb_req, mult_stall); else passed++;
        payC = rand_cpl(); cf = payC;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checks++; if (cdb_req !== 1'b0) $display("[TB] FAIL flush_discard got %b want 0", cdb_req); else passed++;
        applyStimulus(0, 0, 0, 0);
        checks++; if (cdb_req !== 1'b1 || dut_head() !== cf) $display("[TB] FAIL flush_after got req=%b %h want 1 %h", cdb_req, dut_head(), cf); else passed++;
        applyStimulus(0, 0, 0, 1);
        checks++; if (cdb_req !== 1'b0 || mult_stall !== 1'b0) $display("[TB] FAIL flush_idle got req=%b stall=%b want 0/0", cdb_req, mult_stall); else passed++;
    endtask

    task automatic test_random();
        bit fl, fC, fD, iC, iD, gnt;
        for (int n = 0; n < 400; n++) begin
            fl  = ($urandom_range(0, 39) == 0);
            fC  = (mDrop != 0) && ($urandom_range(0, 1) == 1);
            fD  = (mDrop != 0) && ($urandom_range(0, 1) == 1);
            iC  = ($urandom_range(0, 1) == 1);
            iD  = ($urandom_range(0, 1) == 1);
            gnt = ($urandom_range(0, 2) != 0);
            applyStimulus(iC, iD, fl, gnt, fC, fD);
            checks++; if (cdb_req !== (mq.size() != 0)) $display("[TB] FAIL rnd_req cycle %0d got %b want %b", cyc, cdb_req, (mq.size() != 0)); else passed++;
            checks++; if (dut_head() !== exp_head()) $display("[TB] FAIL rnd_head cycle %0d got %h want %h", cyc, dut_head(), exp_head()); else passed++;
            checks++; if (mult_stall !== exp_stall()) $display("[TB] FAIL rnd_stall cycle %0d got %b want %b", cyc, mult_stall, exp_stall()); else passed++;
            checks++; if (overflow_err !== mOvf) $display("[TB] FAIL rnd_ovf cycle %0d got %b want %b", cyc, overflow_err, mOvf); else passed++;
        end
        repeat (12) applyStimulus(0, 0, 0, 1);
        checks++; if (cdb_req !== 1'b0) $display("[TB] FAIL rnd_drain got %b want 0", cdb_req); else passed++;
    endtask

    task automatic test_overflow();
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checks++; if (overflow_err !== 1'b0) $display("[TB] FAIL ovf_early got %b want 0", overflow_err); else passed++;
        applyStimulus(0, 0, 0, 0, 1, 1);
        checks++; if (overflow_err !== 1'b1) $display("[TB] FAIL ovf_set got %b want 1", overflow_err); else passed++;
        checks++; if (mult_stall !== 1'b1) $display("[TB] FAIL ovf_stall got %b want 1", mult_stall); else passed++;
        for (int n = 0; n < 5; n++) begin
            checks++; if (dut_head() !== exp_head()) $display("[TB] FAIL ovf_order step %0d got %h want %h", n, dut_head(), exp_head()); else passed++;
            applyStimulus(0, 0, 0, 1);
        end
        checks++; if (overflow_err !== 1'b1 || cdb_req !== 1'b0) $display("[TB] FAIL ovf_sticky got ovf=%b req=%b want 1/0", overflow_err, cdb_req); else passed++;
    endtask

    task automatic test_reset_mid_drain();
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        checks++; if (cdb_req !== 1'b1 || mult_stall !== 1'b1) $display("[TB] FAIL rst3_pre got req=%b stall=%b want 1/1", cdb_req, mult_stall); else passed++;
        cdb_gnt = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (cdb_req !== 1'b0 || mult_stall !== 1'b0) $display("[TB] FAIL rst3_async got req=%b stall=%b want 0/0", cdb_req, mult_stall); else passed++;
        checks++; if (dut_head() !== MULT_IDLE_CPL || overflow_err !== 1'b0) $display("[TB] FAIL rst3_idle got %h ovf=%b want %h 0", dut_head(), overflow_err, MULT_IDLE_CPL); else passed++;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        mq.delete(); pendC.delete(); pendD.delete(); mInflight = 0; mDrop = 0; mOvf = 1'b0; cyc++;
        applyStimulus(0, 0, 0, 0);
        checks++; if (cdb_req !== 1'b0 || mult_stall !== 1'b0 || overflow_err !== 1'b0) $display("[TB] FAIL rst3_after got req=%b stall=%b ovf=%b want 0/0/0", cdb_req, mult_stall, overflow_err); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single();
        test_dual_same_cycle();
        test_stall_fill();
        test_wrap();
        test_flush();
        test_random();
        test_overflow();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
